// File: rtl/sim_result_checker.sv
// End-of-test monitor: watches the data-memory write bus for the sentinel byte, then
// reads back the answer region and compares it word by word against a golden source.
`timescale 1ns/1ps

module sim_result_checker #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned CHK_W         = 32,
    parameter int unsigned ANSWER_BASE   = 'h9000,
    parameter int unsigned NUM_WORDS     = 16,
    parameter int unsigned SENTINEL_ADDR = 'hfffc,
    parameter logic [7:0]  SENTINEL_VAL  = 8'hff,
    parameter int unsigned MAX_CYCLES    = 50000,
    parameter int unsigned ERR_W         = 8,
    parameter int unsigned IDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_waddr,
    input  logic [XLEN/8-1:0] dm_wstrb,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CHK_W-1:0]  rd_data,
    output logic [IDX_W-1:0]  gold_idx,
    input  logic [CHK_W-1:0]  gold_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [CHK_W-1:0]  first_err_got,
    output logic [31:0]       cycle_count
);

    localparam int unsigned       LANES     = XLEN / 8;
    localparam int unsigned       LANE      = SENTINEL_ADDR % LANES;
    localparam logic [ADDR_W-1:0] SENT_WORD = ADDR_W'(SENTINEL_ADDR & ~(LANES - 1));
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(ANSWER_BASE);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(CHK_W / 8);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'((NUM_WORDS > 0) ? NUM_WORDS - 1 : 0);
    localparam logic [31:0]       LAST_CYC  = 32'(MAX_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    localparam bit                NO_WORDS  = (NUM_WORDS == 0);

    typedef enum logic [2:0] {
        StRun,
        StCheck,
        StDrain,
        StDone,
        StTimeout
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        cycle_q, cycle_d;
    logic               cmp_valid_q;
    logic [IDX_W-1:0]   cmp_idx_q;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               err_seen_q, err_seen_d;
    logic [IDX_W-1:0]   first_idx_q, first_idx_d;
    logic [CHK_W-1:0]   first_got_q, first_got_d;
    logic               done_q, pass_q, timeout_q;
    logic               sentinel_hit;
    logic               mismatch;
    logic               unused_bits;

    // Only the sentinel lane matters; the rest of the bus is observed but ignored.
    assign unused_bits = ^{dm_wstrb, dm_wdata};

    assign sentinel_hit = dm_we && (dm_waddr == SENT_WORD) && dm_wstrb[LANE]
                          && (dm_wdata[8*LANE +: 8] == SENTINEL_VAL);

    // Case inequality so an X/Z read-back is flagged rather than silently matching.
    assign mismatch = cmp_valid_q && (rd_data !== gold_data);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cycle_d = cycle_q;
        unique case (state_q)
            StRun: begin
                if (sentinel_hit) begin
                    state_d = NO_WORDS ? StDrain : StCheck;
                    idx_d   = '0;
                end else if (cycle_q == LAST_CYC) begin
                    state_d = StTimeout;
                end else begin
                    cycle_d = cycle_q + 32'd1;
                end
            end
            StCheck: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDrain: state_d = StDone;
            default: ;
        endcase
    end

    always_comb begin
        err_d       = err_q;
        err_seen_d  = err_seen_q;
        first_idx_d = first_idx_q;
        first_got_d = first_got_q;
        if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!err_seen_q) begin
                err_seen_d  = 1'b1;
                first_idx_d = cmp_idx_q;
                first_got_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            idx_q       <= '0;
            cycle_q     <= '0;
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            err_q       <= '0;
            err_seen_q  <= 1'b0;
            first_idx_q <= '0;
            first_got_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cycle_q     <= cycle_d;
            cmp_valid_q <= rd_en;
            cmp_idx_q   <= idx_q;
            err_q       <= err_d;
            err_seen_q  <= err_seen_d;
            first_idx_q <= first_idx_d;
            first_got_q <= first_got_d;
            done_q      <= (state_d == StDone);
            pass_q      <= (state_d == StDone) && (err_d == '0);
            timeout_q   <= (state_d == StTimeout);
        end
    end

    assign rd_en         = (state_q == StCheck);
    assign rd_addr       = rd_en ? (BASE + ADDR_W'(idx_q) * STRIDE) : '0;
    assign gold_idx      = rd_en ? idx_q : '0;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_count     = err_q;
    assign first_err_idx = first_idx_q;
    assign first_err_got = first_got_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_sim_result_checker.sv
// Bench for sim_result_checker: four instances share the write bus; read traffic and final
// results of the main instance are checked through expectation queues.
`timescale 1ns/1ps

module tb_sim_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        dm_we;
    logic [15:0] dm_waddr;
    logic [7:0]  dm_wstrb;
    logic [63:0] dm_wdata;

    int cyc;
    int n_cmp = 0;
    int n_bad = 0;
    int t_rd_cnt = 0;
    int z_rd_cnt = 0;

    logic [31:0] ans  [8];
    logic [31:0] gold [8];

    // main: 4 words
    logic        m_rd_en, m_done, m_pass, m_timeout;
    logic [15:0] m_rd_addr;
    logic [1:0]  m_gold_idx, m_fidx;
    logic [31:0] m_rd_data, m_gold_data, m_fgot, m_ccount;
    logic [7:0]  m_err;
    logic        m_done_prev;
    // timeout: MAX_CYCLES = 50
    logic        t_rd_en, t_done, t_pass, t_timeout;
    logic [15:0] t_rd_addr;
    logic [1:0]  t_gold_idx, t_fidx;
    logic [31:0] t_fgot, t_ccount;
    logic [7:0]  t_err;
    // zero words
    logic        z_rd_en, z_done, z_pass, z_timeout;
    logic [15:0] z_rd_addr;
    logic [0:0]  z_gold_idx, z_fidx;
    logic [31:0] z_fgot, z_ccount;
    logic [7:0]  z_err;
    // saturation: 8 words, 2-bit error counter
    logic        s_rd_en, s_done, s_pass, s_timeout;
    logic [15:0] s_rd_addr;
    logic [2:0]  s_gold_idx, s_fidx;
    logic [31:0] s_rd_data, s_gold_data, s_fgot, s_ccount;
    logic [1:0]  s_err;

    sim_result_checker #(.NUM_WORDS(4), .MAX_CYCLES(200)) u_main (
        .clk(clk), .rst(rst), .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .rd_en(m_rd_en), .rd_addr(m_rd_addr), .rd_data(m_rd_data),
        .gold_idx(m_gold_idx), .gold_data(m_gold_data), .done(m_done), .pass(m_pass),
        .timeout(m_timeout), .err_count(m_err), .first_err_idx(m_fidx),
        .first_err_got(m_fgot), .cycle_count(m_ccount)
    );

    sim_result_checker #(.NUM_WORDS(4), .MAX_CYCLES(50)) u_tmo (
        .clk(clk), .rst(rst), .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .rd_en(t_rd_en), .rd_addr(t_rd_addr), .rd_data(32'h0),
        .gold_idx(t_gold_idx), .gold_data(32'h0), .done(t_done), .pass(t_pass),
        .timeout(t_timeout), .err_count(t_err), .first_err_idx(t_fidx),
        .first_err_got(t_fgot), .cycle_count(t_ccount)
    );

    sim_result_checker #(.NUM_WORDS(0), .MAX_CYCLES(200)) u_zero (
        .clk(clk), .rst(rst), .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .rd_en(z_rd_en), .rd_addr(z_rd_addr), .rd_data(32'h0),
        .gold_idx(z_gold_idx), .gold_data(32'h0), .done(z_done), .pass(z_pass),
        .timeout(z_timeout), .err_count(z_err), .first_err_idx(z_fidx),
        .first_err_got(z_fgot), .cycle_count(z_ccount)
    );

    sim_result_checker #(.NUM_WORDS(8), .MAX_CYCLES(200), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .gold_idx(s_gold_idx), .gold_data(s_gold_data), .done(s_done), .pass(s_pass),
        .timeout(s_timeout), .err_count(s_err), .first_err_idx(s_fidx),
        .first_err_got(s_fgot), .cycle_count(s_ccount)
    );

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Memory and golden source: one-cycle read latency.
    always @(posedge clk) begin
        if (m_rd_en) m_rd_data <= ans[3'((m_rd_addr - 16'h9000) >> 2)];
        m_gold_data <= gold[{1'b0, m_gold_idx}];
        if (s_rd_en) s_rd_data <= ans[3'((s_rd_addr - 16'h9000) >> 2)];
        s_gold_data <= gold[s_gold_idx];
    end

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  idx;
        int          at;
    } rd_exp_t;

    typedef struct {
        int          at;
        logic        pass;
        logic [7:0]  err;
        logic [1:0]  fidx;
        logic [31:0] fgot;
        logic [31:0] ccount;
    } res_exp_t;

    rd_exp_t  rd_q [$];
    res_exp_t res_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected reads and final result of u_main for a sentinel seen at cycle t.
    task automatic push_expect(input int t);
        rd_exp_t  r;
        res_exp_t e;
        bit       seen = 1'b0;
        e.err  = 8'd0;
        e.fidx = 2'd0;
        e.fgot = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r.addr = 16'h9000 + 16'(4 * i);
            r.idx  = 2'(i);
            r.at   = t + 1 + i;
            rd_q.push_back(r);
            if (ans[i] !== gold[i]) begin
                e.err = e.err + 8'd1;
                if (!seen) begin
                    seen   = 1'b1;
                    e.fidx = 2'(i);
                    e.fgot = ans[i];
                end
            end
        end
        e.at     = t + 6;
        e.pass   = (e.err == 8'd0);
        e.ccount = 32'(t);
        res_q.push_back(e);
    endtask

    always @(negedge clk) begin
        rd_exp_t  r;
        res_exp_t e;
        if (rst) begin
            m_done_prev = 1'b0;
        end else begin
            if (m_rd_en) begin
                check_eq("rd_expected", rd_q.size() > 0, 1'b1);
                if (rd_q.size() > 0) begin
                    r = rd_q.pop_front();
                    check_eq("rd_addr", m_rd_addr, r.addr);
                    check_eq("gold_idx", m_gold_idx, r.idx);
                    check_eq("rd_cycle", cyc, r.at);
                end
            end
            if (m_done && !m_done_prev) begin
                check_eq("done_expected", res_q.size() > 0, 1'b1);
                if (res_q.size() > 0) begin
                    e = res_q.pop_front();
                    check_eq("done_cycle", cyc, e.at);
                    check_eq("pass", m_pass, e.pass);
                    check_eq("err_count", m_err, e.err);
                    check_eq("first_err_idx", m_fidx, e.fidx);
                    check_eq("first_err_got", m_fgot, e.fgot);
                    check_eq("cycle_count", m_ccount, e.ccount);
                end
            end
            m_done_prev = m_done;
            if (t_rd_en) t_rd_cnt++;
            if (z_rd_en) z_rd_cnt++;
        end
    end

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_q.delete();
        res_q.delete();
    endtask

    task automatic send_write(input logic [15:0] addr, input logic [7:0] strb,
                              input logic [63:0] data, input bit hit);
        if (hit) push_expect(cyc);
        dm_we    = 1'b1;
        dm_waddr = addr;
        dm_wstrb = strb;
        dm_wdata = data;
        @(posedge clk);
        #1;
        dm_we    = 1'b0;
        dm_waddr = '0;
        dm_wstrb = '0;
        dm_wdata = '0;
    endtask

    task automatic wait_main_done(input int limit);
        while (res_q.size() > 0 && cyc < limit) begin
            @(posedge clk);
            #1;
        end
        check_eq("main_done_wait", res_q.size(), 0);
    endtask

    task automatic check_main_reset(input string tag);
        check_eq({tag, "_ctl"}, {m_rd_en, m_rd_addr, m_gold_idx, m_done, m_pass, m_timeout,
                                 m_err, m_fidx}, '0);
        check_eq({tag, "_data"}, {m_fgot, m_ccount}, '0);
    endtask

    localparam logic [63:0] HIT_DATA = 64'h0000_00ff_0000_0000;

    initial begin
        rst      = 1'b1;
        dm_we    = 1'b0;
        dm_waddr = '0;
        dm_wstrb = '0;
        dm_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            ans[i]  = 32'(i + 1);
            gold[i] = 32'(i + 1);
        end

        // All words match; near-miss writes before the real sentinel.
        do_reset();
        @(negedge clk);
        check_main_reset("reset");
        check_eq("tmo_reset", {t_timeout, t_done, t_ccount}, '0);
        step_to(40);
        send_write(16'hfff8, 8'h0f, HIT_DATA, 1'b0);
        step_to(42);
        send_write(16'hfff8, 8'hf0, 64'h0000_00fe_0000_0000, 1'b0);
        step_to(44);
        send_write(16'hfff0, 8'hf0, HIT_DATA, 1'b0);
        step_to(49);
        @(negedge clk);
        check_eq("tmo_before", t_timeout, 1'b0);
        step_to(50);
        @(negedge clk);
        check_eq("tmo_flag", t_timeout, 1'b1);
        check_eq("tmo_done_pass", {t_done, t_pass}, 2'b00);
        step_to(100);
        send_write(16'hfff8, 8'hf0, HIT_DATA, 1'b1);
        @(negedge clk);
        check_eq("zero_done_early", z_done, 1'b0);
        step_to(102);
        @(negedge clk);
        check_eq("zero_done_pass", {z_done, z_pass}, 2'b11);
        wait_main_done(130);
        step_to(140);
        send_write(16'hfff8, 8'hf0, HIT_DATA, 1'b0);
        step_to(150);
        @(negedge clk);
        check_eq("main_terminal", {m_done, m_pass}, 2'b11);
        check_eq("main_count_frozen", m_ccount, 32'd100);
        check_eq("tmo_terminal", {t_timeout, t_done}, 2'b10);
        check_eq("tmo_count", t_ccount, 32'd49);
        check_eq("tmo_no_reads", t_rd_cnt, 0);
        check_eq("zero_no_reads", z_rd_cnt, 0);
        check_eq("zero_count", z_ccount, 32'd100);

        // Mismatches: two for u_main, five for u_sat (saturating at 3).
        ans[2] = 32'hdead;
        ans[3] = 32'h0;
        ans[4] = 32'h0;
        ans[5] = 32'h0;
        ans[6] = 32'h0;
        do_reset();
        step_to(100);
        send_write(16'hfff8, 8'h10, HIT_DATA, 1'b1);
        wait_main_done(130);
        step_to(109);
        @(negedge clk);
        check_eq("sat_done_early", s_done, 1'b0);
        step_to(110);
        @(negedge clk);
        check_eq("sat_done_pass", {s_done, s_pass}, 2'b10);
        check_eq("sat_err_count", s_err, 2'd3);
        check_eq("sat_first_idx", s_fidx, 3'd2);
        check_eq("sat_first_got", s_fgot, 32'hdead);

        // Reset during the second CHECK cycle; the aborted word-1 compare must not count.
        for (int i = 0; i < 8; i++) ans[i] = 32'(i + 1);
        ans[1] = 32'hbad0_bad0;
        do_reset();
        step_to(20);
        send_write(16'hfff8, 8'hf0, HIT_DATA, 1'b1);
        step_to(22);
        do_reset();
        @(negedge clk);
        check_main_reset("abort");
        ans[1] = 32'd2;
        step_to(30);
        send_write(16'hfff8, 8'hf0, HIT_DATA, 1'b1);
        wait_main_done(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sim_result_checker.md
Name: sim_result_checker

Overview:
- Synthesizable end-of-test monitor for the RV32I/RV64I CPU simulation and FPGA builds.
- Snoops the data-memory write bus for the end-of-test sentinel byte. It also enforces a cycle-count timeout.
- After the sentinel, reads the answer region through a dedicated memory read port and compares each word against a golden source.
- Reports done, pass or timeout, an error count and the first mismatch.

Parameters:
- XLEN, 64, data-bus width of the snooped write port (32 or 64).
- ADDR_W, 16, byte-address width.
- CHK_W, 32, width of each compared answer word (32 or 64, CHK_W <= XLEN).
- ANSWER_BASE, 'h9000, byte address of answer word 0.
- NUM_WORDS, 16, number of answer words compared (0 allowed).
- SENTINEL_ADDR, 'hfffc, byte address of the sentinel byte.
- SENTINEL_VAL, 8'hff, sentinel byte value.
- MAX_CYCLES, 50000, cycles allowed in RUN before timeout.
- ERR_W, 8, error-counter width.
- IDX_W, max(1,clog2(NUM_WORDS)), index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dm_we  in  1  data-memory write enable (snooped)
- dm_waddr  in  ADDR_W  write byte address, XLEN/8-aligned
- dm_wstrb  in  XLEN/8  byte-lane strobes
- dm_wdata  in  XLEN  write data
- rd_en  out  1  answer read request
- rd_addr  out  ADDR_W  answer read byte address
- rd_data  in  CHK_W  read data, valid exactly 1 cycle after rd_en
- gold_idx  out  IDX_W  golden word index, driven with rd_en
- gold_data  in  CHK_W  golden word, valid 1 cycle after rd_en
- done  out  1  comparison finished
- pass  out  1  done with zero errors
- timeout  out  1  MAX_CYCLES elapsed without sentinel
- err_count  out  ERR_W  mismatches, saturating
- first_err_idx  out  IDX_W  index of the first mismatch
- first_err_got  out  CHK_W  rd_data at the first mismatch
- cycle_count  out  32  cycles spent in RUN

Behaviour:
- Reset: synchronous on rst=1. All outputs are 0; state goes to RUN, cycle_count to 0, first-error capture is armed.
- States: RUN, CHECK, DRAIN, DONE, TIMEOUT.
- Sentinel hit: dm_we=1, dm_waddr equals SENTINEL_ADDR with its low clog2(XLEN/8) bits cleared, lane L = SENTINEL_ADDR mod (XLEN/8), dm_wstrb[L]=1 and dm_wdata[8L+7:8L]==SENTINEL_VAL.
- RUN: cycle_count increments each cycle.
  - Sentinel hit at cycle T: go to CHECK at T+1, or to DRAIN if NUM_WORDS=0.
  - Else, if cycle_count==MAX_CYCLES-1: go to TIMEOUT.
  - Sentinel and timeout in the same cycle: the sentinel wins.
- CHECK: for i=0..NUM_WORDS-1 on consecutive cycles, issue rd_en=1, rd_addr=ANSWER_BASE+i*(CHK_W/8), gold_idx=i. After the last issue, go to DRAIN.
- Compare: in the cycle after each rd_en, compare rd_data against gold_data; mismatch means !==, so X/Z counts as an error.
  - On mismatch, err_count increments, saturating at 2^ERR_W-1.
  - The first mismatch latches first_err_idx and first_err_got; later mismatches do not update them.
- DRAIN: one cycle for the last compare. Then DONE: done=1 and pass=(err_count==0), both registered at cycle T+NUM_WORDS+2.
- DONE and TIMEOUT are terminal until rst. All later dm writes, including repeated sentinels, are ignored.
- TIMEOUT: timeout=1, done=0, pass=0, no reads issued.
- cycle_count freezes on leaving RUN.
- rd_en is 0 outside CHECK.
- rst asserted mid-CHECK aborts the in-flight compare; its returning data is ignored.
- Non-sentinel writes, and sentinel-address writes with a wrong value or cleared strobe, have no effect.

Test Plan:
- Sentinel at cycle 100, NUM_WORDS=4, gold=rd={1,2,3,4} -> rd_addr 9000,9004,9008,900c on cycles 101-104; done=pass=1 at cycle 106; err_count=0; cycle_count=100.
- Same, rd word 2 = 'hDEAD vs gold 3 and word 3 = 0 vs gold 4 -> err_count=2, first_err_idx=2, first_err_got='hDEAD, pass=0, done=1.
- No sentinel, MAX_CYCLES=50 -> timeout=1 after cycle 49; done=0; rd_en never asserted; later sentinel ignored.
- XLEN=64, write to 'hfff8 with wstrb='hF0 and byte4='hFF -> hit. Wstrb='h0F with the same data -> no hit. Byte4='hFE -> no hit.
- NUM_WORDS=0 with sentinel at T -> done=pass=1 at T+2, no rd_en. ERR_W=2 with 5 mismatches -> err_count=3.
- rst pulsed at the 2nd CHECK cycle -> all outputs 0 next cycle. A fresh sentinel then rechecks from index 0.
